// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control inputs, instruction-memory bus and F->X outputs of the fetch stage
interface fetch_stage_if #(
  parameter int IMEM_AW = 14,
  parameter int BIOS_AW = 12
);
  logic               stall;
  logic [2:0]         pc_sel;
  logic [31:0]        alu_target;
  logic [31:0]        jal_target;
  logic [IMEM_AW-1:0] imem_addr;
  logic [BIOS_AW-1:0] bios_addr;
  logic [31:0]        imem_dout;
  logic [31:0]        bios_dout;
  logic [31:0]        pc_f;
  logic [31:0]        instr_x;
  logic [31:0]        pc_x;
  logic               valid_x;
  logic               cnt_clr;
  logic [31:0]        cycle_cnt;
  logic [31:0]        instr_cnt;
  modport master (
    output stall, pc_sel, alu_target, jal_target, imem_dout, bios_dout, cnt_clr,
    input  imem_addr, bios_addr, pc_f, instr_x, pc_x, valid_x, cycle_cnt, instr_cnt
  );
  modport slave (
    input  stall, pc_sel, alu_target, jal_target, imem_dout, bios_dout, cnt_clr,
    output imem_addr, bios_addr, pc_f, instr_x, pc_x, valid_x, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select, BIOS/IMEM fetch, F->X register with redirect squash and counters
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          IMEM_AW  = 14,
  parameter int          BIOS_AW  = 12,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input logic         clk,
  input logic         rst,
  fetch_stage_if.slave io_bus
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc_f, r_instr_x, r_pc_x, r_cycle_cnt, r_instr_cnt;
  logic        r_valid_x;
  logic [31:0] w_seq_pc, w_sel_pc, w_next_pc, w_fetch;
  logic        w_redirect, w_bios, w_imem, w_fvalid;
  logic        w_unused;
  always_comb begin
    w_seq_pc    = r_pc_f + 32'd4;
    w_sel_pc    = io_bus.pc_sel == 3'd0 ? RESET_PC :
                  io_bus.pc_sel == 3'd2 ? w_seq_pc :
                  io_bus.pc_sel == 3'd3 ? {io_bus.alu_target[31:2], 2'b00} :
                  io_bus.pc_sel == 3'd4 ? {io_bus.jal_target[31:2], 2'b00} : r_pc_f;
    w_next_pc   = rst ? RESET_PC : io_bus.stall ? r_pc_f : r_state == BOOT ? w_seq_pc : w_sel_pc;
    w_redirect  = r_state == RUN && !io_bus.stall &&
                  (io_bus.pc_sel == 3'd0 || io_bus.pc_sel == 3'd3 || io_bus.pc_sel == 3'd4);
    w_bios      = r_pc_f[31:28] == 4'b0100;
    w_imem      = r_pc_f[31:28] == 4'b0001;
    // BOOT and redirects squash whatever word is sitting on the memory outputs
    w_fvalid    = (w_bios || w_imem) && r_state == RUN && !w_redirect;
    w_fetch     = !w_fvalid ? NOP : w_bios ? io_bus.bios_dout : io_bus.imem_dout;
    w_state_nxt = io_bus.stall ? r_state : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BOOT;
      r_pc_f      <= RESET_PC;
      r_instr_x   <= NOP;
      r_pc_x      <= RESET_PC;
      r_valid_x   <= 1'b0;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cycle_cnt <= io_bus.cnt_clr ? '0 : r_cycle_cnt + 32'd1;
      r_instr_cnt <= io_bus.cnt_clr ? '0 : r_instr_cnt + {31'd0, !io_bus.stall && w_fvalid};
      if (!io_bus.stall) begin
        r_pc_f    <= w_next_pc;
        r_instr_x <= w_fetch;
        r_pc_x    <= r_pc_f;
        r_valid_x <= w_fvalid;
      end
    end
  end
  assign io_bus.imem_addr = w_next_pc[IMEM_AW+1:2];
  assign io_bus.bios_addr = w_next_pc[BIOS_AW+1:2];
  assign io_bus.pc_f      = r_pc_f;
  assign io_bus.instr_x   = r_instr_x;
  assign io_bus.pc_x      = r_pc_x;
  assign io_bus.valid_x   = r_valid_x;
  assign io_bus.cycle_cnt = r_cycle_cnt;
  assign io_bus.instr_cnt = r_instr_cnt;
  assign w_unused         = ^{io_bus.alu_target[1:0], io_bus.jal_target[1:0]};
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table through a scoreboard queue plus hand-written address/reset sequences
module tb_fetch_stage;
  localparam logic [31:0] R   = 32'h4000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          NV  = 29;
  typedef struct {
    logic        rst, stall, clr;
    logic [2:0]  sel;
    logic [31:0] alu, jal, pc_f, instr, pc_x;
    logic        valid;
    logic [31:0] icnt, ccnt;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NV];
  vec_t q[$];
  vec_t e;
  fetch_stage_if #(.IMEM_AW(14), .BIOS_AW(12)) bus();
  fetch_stage dut (.clk(clk), .rst(rst), .io_bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    bus.bios_dout <= 32'hB000_0000 | 32'(bus.bios_addr);
    bus.imem_dout <= 32'hA000_0000 | 32'(bus.imem_addr);
  end
  function automatic logic [31:0] bw(input logic [31:0] p);
    return 32'hB000_0000 | {20'd0, p[13:2]};
  endfunction
  function automatic logic [31:0] iw(input logic [31:0] p);
    return 32'hA000_0000 | {18'd0, p[15:2]};
  endfunction
  function automatic vec_t mk(input logic r, s, c, input logic [2:0] sl, input logic [31:0] a, j,
                              pf, ins, px, input logic v, input logic [31:0] ic, cc);
    vec_t t;
    t.rst = r; t.stall = s; t.clr = c; t.sel = sl; t.alu = a; t.jal = j;
    t.pc_f = pf; t.instr = ins; t.pc_x = px; t.valid = v; t.icnt = ic; t.ccnt = cc;
    return t;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    rst = 1'b1; bus.stall = 1'b0; bus.pc_sel = 3'd2; bus.alu_target = '0; bus.jal_target = '0; bus.cnt_clr = 1'b0;
    vecs[0]  = mk(1,0,0,3'd2,0,0, R, NOP, R, 0, 0, 0);
    vecs[1]  = mk(1,0,0,3'd2,0,0, R, NOP, R, 0, 0, 0);
    vecs[2]  = mk(1,0,0,3'd2,0,0, R, NOP, R, 0, 0, 0);
    vecs[3]  = mk(0,0,0,3'd3,32'h1000_0000,0, R+4, NOP, R, 0, 0, 1);
    vecs[4]  = mk(0,0,0,3'd2,0,0, R+8,  bw(R+4),  R+4,  1, 1, 2);
    vecs[5]  = mk(0,0,0,3'd2,0,0, R+12, bw(R+8),  R+8,  1, 2, 3);
    vecs[6]  = mk(0,0,0,3'd2,0,0, R+16, bw(R+12), R+12, 1, 3, 4);
    vecs[7]  = mk(0,0,0,3'd2,0,0, R+20, bw(R+16), R+16, 1, 4, 5);
    vecs[8]  = mk(0,0,0,3'd3,32'h1000_0102,0, 32'h1000_0100, NOP, R+20, 0, 4, 6);
    vecs[9]  = mk(0,0,0,3'd2,0,0, 32'h1000_0104, iw(32'h1000_0100), 32'h1000_0100, 1, 5, 7);
    vecs[10] = mk(0,1,0,3'd4,0,32'h1000_0203, 32'h1000_0104, 32'hA000_0040, 32'h1000_0100, 1, 5, 8);
    vecs[11] = mk(0,1,0,3'd4,0,32'h1000_0203, 32'h1000_0104, 32'hA000_0040, 32'h1000_0100, 1, 5, 9);
    vecs[12] = mk(0,1,0,3'd4,0,32'h1000_0203, 32'h1000_0104, 32'hA000_0040, 32'h1000_0100, 1, 5, 10);
    vecs[13] = mk(0,0,0,3'd4,0,32'h1000_0203, 32'h1000_0200, NOP, 32'h1000_0104, 0, 5, 11);
    vecs[14] = mk(0,0,0,3'd2,0,0, 32'h1000_0204, iw(32'h1000_0200), 32'h1000_0200, 1, 6, 12);
    vecs[15] = mk(0,0,0,3'd3,32'h2000_0000,0, 32'h2000_0000, NOP, 32'h1000_0204, 0, 6, 13);
    vecs[16] = mk(0,0,0,3'd2,0,0, 32'h2000_0004, NOP, 32'h2000_0000, 0, 6, 14);
    vecs[17] = mk(0,0,0,3'd4,0,32'h1000_0000, 32'h1000_0000, NOP, 32'h2000_0004, 0, 6, 15);
    vecs[18] = mk(0,0,1,3'd2,0,0, 32'h1000_0004, iw(32'h1000_0000), 32'h1000_0000, 1, 0, 0);
    vecs[19] = mk(0,0,0,3'd1,0,0, 32'h1000_0004, iw(32'h1000_0004), 32'h1000_0004, 1, 1, 1);
    vecs[20] = mk(0,0,0,3'd5,0,0, 32'h1000_0004, iw(32'h1000_0004), 32'h1000_0004, 1, 2, 2);
    vecs[21] = mk(0,0,0,3'd3,32'hFFFF_FFFF,0, 32'hFFFF_FFFC, NOP, 32'h1000_0004, 0, 2, 3);
    vecs[22] = mk(0,0,0,3'd2,0,0, 32'h0000_0000, NOP, 32'hFFFF_FFFC, 0, 2, 4);
    vecs[23] = mk(0,0,0,3'd0,0,0, R, NOP, 32'h0000_0000, 0, 2, 5);
    vecs[24] = mk(0,0,0,3'd2,0,0, R+4, bw(R), R, 1, 3, 6);
    vecs[25] = mk(1,1,0,3'd4,0,32'h1000_0000, R, NOP, R, 0, 0, 0);
    vecs[26] = mk(0,1,0,3'd2,0,0, R, NOP, R, 0, 0, 1);
    vecs[27] = mk(0,0,0,3'd2,0,0, R+4, NOP, R, 0, 0, 2);
    vecs[28] = mk(0,0,0,3'd2,0,0, R+8, bw(R+4), R+4, 1, 1, 3);
    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; bus.stall = vecs[i].stall; bus.cnt_clr = vecs[i].clr; bus.pc_sel = vecs[i].sel;
      bus.alu_target = vecs[i].alu; bus.jal_target = vecs[i].jal;
      q.push_back(vecs[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      check($sformatf("v%0d pc_f", i), bus.pc_f, e.pc_f);
      check($sformatf("v%0d instr_x", i), bus.instr_x, e.instr);
      check($sformatf("v%0d pc_x", i), bus.pc_x, e.pc_x);
      check($sformatf("v%0d valid_x", i), {31'd0, bus.valid_x}, {31'd0, e.valid});
      check($sformatf("v%0d instr_cnt", i), bus.instr_cnt, e.icnt);
      check($sformatf("v%0d cycle_cnt", i), bus.cycle_cnt, e.ccnt);
    end
    bus.stall = 1'b1; bus.pc_sel = 3'd3; bus.alu_target = 32'h1000_0104; #1;
    check("stall bios_addr", 32'(bus.bios_addr), 32'h2);
    check("stall imem_addr", 32'(bus.imem_addr), 32'h2);
    bus.stall = 1'b0; #1;
    check("branch imem_addr", 32'(bus.imem_addr), 32'h41);
    check("branch bios_addr", 32'(bus.bios_addr), 32'h41);
    @(posedge clk); #1;
    check("branch pc_f", bus.pc_f, 32'h1000_0104);
    check("branch valid_x", {31'd0, bus.valid_x}, 32'd0);
    bus.pc_sel = 3'd2; rst = 1'b1; #1;
    check("rst bios_addr", 32'(bus.bios_addr), 32'h0);
    @(posedge clk); #1;
    check("rst pc_f", bus.pc_f, R);
    check("rst cycle_cnt", bus.cycle_cnt, 32'd0);
    rst = 1'b0; bus.stall = 1'b1; bus.cnt_clr = 1'b1;
    @(posedge clk); #1;
    check("clr during stall cycle_cnt", bus.cycle_cnt, 32'd0);
    bus.cnt_clr = 1'b0;
    @(posedge clk); #1;
    check("stall cycle_cnt advance", bus.cycle_cnt, 32'd1);
    check("stall boot pc_f", bus.pc_f, R);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
